registru_piso: RTL and testbench

Parallel-in serial-out transmit shift register, the transmitting end of the serial-in parallel-out receive register. It accepts a WIDTH-bit word through a ready/valid load handshake and shifts it out one bit at a time on `sout`. A programmable hold count sets how many clocks each bit stays on the line. Back-to-back words stream with no idle cycle between them.

---
 rtl/registru_piso.sv | 90 +++++++++
 tb/tb_registru_piso.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/registru_piso.sv
// registru_piso: parallel-in serial-out transmit shift register.
// A word is loaded through a ready/valid handshake and sent one bit at a
// time on sout. Each bit is held for DIV unpaused clocks. A new word can be
// accepted on the edge that ends the last bit, so back-to-back words leave
// no idle cycle between them.
module registru_piso #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned DIV        = 1,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             pause,
    output logic             sout,
    output logic             sout_valid,
    output logic             first,
    output logic             done
);

    localparam int unsigned BW = $clog2(WIDTH);
    // A one-bit hold counter is kept when DIV==1 so the vector is never zero width.
    localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] sr;
    logic [BW-1:0]    bitcnt;
    logic [DW-1:0]    divcnt;

    logic last_bit;
    logic last_hold;
    logic head;
    logic accept;

    assign last_bit  = (bitcnt == BW'(WIDTH - 1));
    assign last_hold = (divcnt == DW'(DIV - 1));
    assign head      = MSB_FIRST ? sr[WIDTH-1] : sr[0];

    // Outputs are decoded only from state registers, so they never glitch
    // with inputs and fall to their idle values as soon as reset asserts.
    assign sout       = (state == SHIFT) ? head : IDLE_LEVEL;
    assign sout_valid = (state == SHIFT);
    assign first      = (state == SHIFT) && (bitcnt == '0);
    assign done       = (state == SHIFT) && last_bit && last_hold;

    // NOTE: load_ready is combinational on purpose: it must rise in the final
    // clock of a word so the next word is captured on the same edge, no gap.
    assign load_ready = (state == IDLE) || (done && !pause);
    assign accept     = load_valid && load_ready;

    // Load / hold / shift sequencing; a pending accept takes priority over
    // the end-of-word return to IDLE.
    // NOTE: every register here uses non-blocking assignment so all of them
    // update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sr     <= '0;
            bitcnt <= '0;
            divcnt <= '0;
        end else if (accept) begin
            state  <= SHIFT;
            sr     <= din;
            bitcnt <= '0;
            divcnt <= '0;
        end else if (state == SHIFT && !pause) begin
            if (last_hold) begin
                divcnt <= '0;
                sr     <= MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
                if (last_bit) begin
                    state  <= IDLE;
                    bitcnt <= '0;
                end else begin
                    bitcnt <= bitcnt + 1'b1;
                end
            end else begin
                divcnt <= divcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_registru_piso.sv
// Bench for registru_piso. Two instances: index 0 is WIDTH=4, DIV=1,
// MSB first; index 1 is WIDTH=4, DIV=3, LSB first. A word-level model
// predicts every output each cycle; directed sequences also pin literal
// bit streams.
module tb_registru_piso;

    localparam int W = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] din        [2];
    logic       lv         [2];
    logic       pz         [2];
    logic       rdy        [2];
    logic       so         [2];
    logic       sv         [2];
    logic       fst        [2];
    logic       dn         [2];

    int n_chk  = 0;
    int n_pass = 0;

    registru_piso #(.WIDTH(4), .DIV(1), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .din(din[0]), .load_valid(lv[0]), .load_ready(rdy[0]),
        .pause(pz[0]), .sout(so[0]), .sout_valid(sv[0]), .first(fst[0]), .done(dn[0])
    );

    registru_piso #(.WIDTH(4), .DIV(3), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .din(din[1]), .load_valid(lv[1]), .load_ready(rdy[1]),
        .pause(pz[1]), .sout(so[1]), .sout_valid(sv[1]), .first(fst[1]), .done(dn[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- word-level model ----------------
    // A word in flight is a position t in 0..W*div-1 counted over unpaused
    // clocks; the bit on the line is word bit number t/div in send order.
    logic [3:0] m_word [2];
    int         m_t    [2];
    bit         m_act  [2];

    function automatic int dv_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic exp_done(input int i);
        return m_act[i] && (m_t[i] == W * dv_of(i) - 1);
    endfunction

    function automatic logic exp_rdy(input int i);
        return !m_act[i] || (exp_done(i) && !pz[i]);
    endfunction

    function automatic logic exp_sout(input int i);
        int b;
        b = m_t[i] / dv_of(i);
        if (!m_act[i]) return 1'b0;
        return (i == 0) ? m_word[i][W-1-b] : m_word[i][b];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_act[i]  <= 1'b0;
                m_t[i]    <= 0;
                m_word[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (lv[i] && exp_rdy(i)) begin
                    m_word[i] <= din[i];
                    m_t[i]    <= 0;
                    m_act[i]  <= 1'b1;
                end else if (m_act[i] && !pz[i]) begin
                    if (m_t[i] == W * dv_of(i) - 1) m_act[i] <= 1'b0;
                    else m_t[i] <= m_t[i] + 1;
                end
            end
        end
    end

    // Every-cycle compare of both instances against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("m%0d_sout", i),  32'(so[i]),  32'(exp_sout(i)));
            check($sformatf("m%0d_valid", i), 32'(sv[i]),  32'(m_act[i]));
            check($sformatf("m%0d_first", i), 32'(fst[i]), 32'(m_act[i] && m_t[i] < dv_of(i)));
            check($sformatf("m%0d_done", i),  32'(dn[i]),  32'(exp_done(i)));
            check($sformatf("m%0d_ready", i), 32'(rdy[i]), 32'(exp_rdy(i)));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int i, input logic [3:0] w);
        lv[i]  = 1'b1;
        din[i] = w;
        step();
        lv[i]  = 1'b0;
        din[i] = 4'($urandom_range(0, 15));
    endtask

    logic [7:0]  s8, v8, f8;
    logic [11:0] s12, d12;

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            lv[i] = 1'b0; pz[i] = 1'b0; din[i] = '0;
        end
        step(); step();
        check("rst_sout", 32'(so[0]), 32'd0);
        check("rst_valid", 32'(sv[0]), 32'd0);
        check("rst_ready", 32'(rdy[0]), 32'd1);
        rst_n = 1'b1;

        // Basic MSB first: 1011 -> 1,0,1,1
        load(0, 4'b1011);
        s8 = '0; v8 = '0; f8 = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            s8[3-k] = so[0]; v8[3-k] = sv[0]; f8[3-k] = fst[0];
            if (k == 3) check("basic_done_clk4", 32'(dn[0]), 32'd1);
            step();
        end
        check("basic_bits", 32'(s8[3:0]), 32'hB);
        check("basic_valid", 32'(v8[3:0]), 32'hF);
        check("basic_first", 32'(f8[3:0]), 32'h8);
        @(negedge clk);
        check("basic_after_sout", 32'(so[0]), 32'd0);
        check("basic_after_valid", 32'(sv[0]), 32'd0);
        check("basic_after_ready", 32'(rdy[0]), 32'd1);
        step();

        // Back-to-back: 1100 then 0011 with no gap
        lv[0] = 1'b1; din[0] = 4'b1100;
        step();
        s8 = '0; v8 = '0; f8 = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            s8[7-k] = so[0]; v8[7-k] = sv[0]; f8[7-k] = fst[0];
            if (k == 3) begin
                check("b2b_done_w1", 32'(dn[0]), 32'd1);
                din[0] = 4'b0011;
            end
            if (k == 7) lv[0] = 1'b0;
            step();
        end
        check("b2b_bits", 32'(s8), 32'hC3);
        check("b2b_valid", 32'(v8), 32'hFF);
        check("b2b_first", 32'(f8), 32'h88);
        @(negedge clk);
        check("b2b_end_valid", 32'(sv[0]), 32'd0);
        step();

        // Hold and LSB-first order on the DIV=3 instance: 0110
        load(1, 4'b0110);
        s12 = '0; d12 = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            s12[11-k] = so[1]; d12[11-k] = dn[1];
            step();
        end
        check("hold_bits", 32'(s12), 32'h1F8);
        check("hold_done", 32'(d12), 32'h001);
        @(negedge clk);
        check("hold_end_valid", 32'(sv[1]), 32'd0);
        step();

        // Ignored load and pause: 1001, 1111 offered mid-word, pause 2 clocks
        load(0, 4'b1001);
        s8 = '0;
        for (int k = 0; k < 7; k++) begin
            if (k == 1) begin lv[0] = 1'b1; din[0] = 4'b1111; end
            if (k == 2) begin lv[0] = 1'b0; pz[0] = 1'b1; end
            if (k == 4) pz[0] = 1'b0;
            @(negedge clk);
            if (k == 1) check("ign_ready", 32'(rdy[0]), 32'd0);
            if (k < 6) s8[5-k] = so[0];
            if (k == 6) check("ign_not_sent", 32'(sv[0]), 32'd0);
            step();
        end
        check("pause_bits", 32'(s8[5:0]), 32'h21);

        // Reset mid-word: 1111 interrupted during bit 2
        load(0, 4'b1111);
        step();
        #2 rst_n = 1'b0;
        #1;
        check("amid_rst_sout", 32'(so[0]), 32'd0);
        check("amid_rst_valid", 32'(sv[0]), 32'd0);
        check("amid_rst_ready", 32'(rdy[0]), 32'd1);
        step();
        rst_n = 1'b1;
        load(0, 4'b0101);
        s8 = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            s8[4-k] = so[0];
            step();
        end
        check("post_rst_bits", 32'(s8[4:0]), 32'h0A);

        step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
